// File: rtl/dht_pkg.sv
// Shared types, constants and frame-check helpers for the DHT single-wire sensor controller.
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RESP_LOW  = 3'd3,
    ST_RESP_HIGH = 3'd4,
    ST_BIT_LOW   = 3'd5,
    ST_BIT_HIGH  = 3'd6,
    ST_CHECK     = 3'd7
  } dht_state_e;

  localparam int DHT11_START_US = 18000;
  localparam int DHT22_START_US = 1000;
  localparam int FRAME_BITS     = 40;

  // 8-bit wrapping sum of the four payload bytes.
  function automatic logic [7:0] dht_checksum(input logic [39:0] frame);
    return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  endfunction

  // An all-zero frame matches its own checksum but means a dead line, so reject it.
  function automatic logic dht_frame_ok(input logic [39:0] frame);
    return (dht_checksum(frame) == frame[7:0]) && (frame != 40'd0);
  endfunction

endpackage

// File: rtl/dht_sensor_ctrl_if.sv
// Host-side handshake and decoded-data bundle of the DHT sensor controller.
interface dht_sensor_ctrl_if;

  logic        start;
  logic        mode;
  logic        busy;
  logic        data_valid;
  logic        err_timeout;
  logic        err_checksum;
  logic [39:0] raw;
  logic [15:0] humidity;
  logic [15:0] temperature;

  modport master (
    output start, mode,
    input  busy, data_valid, err_timeout, err_checksum, raw, humidity, temperature
  );

  modport slave (
    input  start, mode,
    output busy, data_valid, err_timeout, err_checksum, raw, humidity, temperature
  );

endinterface

// File: rtl/dht_us_tick.sv
// Free-running 1 us clock-enable and a 1 ms clock-enable derived from it.
module dht_us_tick #(
  parameter int CLK_FREQ_HZ = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic ms_tick
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt_r;
  logic [9:0]    us_cnt_r;
  logic          tick_r;
  logic          ms_tick_r;

  // Divider chain: clocks to microseconds to milliseconds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DW{1'b0}};
      us_cnt_r  <= 10'd0;
      tick_r    <= 1'b0;
      ms_tick_r <= 1'b0;
    end else begin
      if (div_cnt_r == DW'(DIV - 1)) begin
        div_cnt_r <= {DW{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + DW'(1);
      end
      tick_r    <= (div_cnt_r == DW'(DIV - 1));
      ms_tick_r <= tick_r && (us_cnt_r == 10'd999);
      if (tick_r) begin
        us_cnt_r <= (us_cnt_r == 10'd999) ? 10'd0 : us_cnt_r + 10'd1;
      end
    end
  end

  assign tick    = tick_r;
  assign ms_tick = ms_tick_r;

endmodule

// File: rtl/dht_sensor_ctrl.sv
// DHT11/DHT22 single-wire controller: start pulse, response/bit decode, checksum, timeouts.
// Optional DHT_GLITCH_FILT_EN: line level must be stable 4 clk cycles before it is accepted.
module dht_sensor_ctrl #(
  parameter int CLK_FREQ_HZ      = 25_000_000,
  parameter int POLL_PERIOD_MS   = 2000,
  parameter int BIT_THRESH_US    = 40,
  parameter int PHASE_TIMEOUT_US = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dq_i,
  output logic              dq_oe,
  dht_sensor_ctrl_if.slave  bus
);

  import dht_pkg::*;

  logic        tick_s;
  logic        ms_tick_s;
  logic [1:0]  sync_r;
  logic        line_s;
  logic        line_prev_r;
  logic        rise_s;
  logic        fall_s;

  dht_state_e  state_r;
  dht_state_e  state_nxt_s;
  logic [15:0] phase_cnt_r;
  logic [15:0] poll_cnt_r;
  logic [7:0]  width_cnt_r;
  logic [5:0]  bit_cnt_r;
  logic [39:0] shift_r;
  logic [39:0] raw_r;
  logic        mode_r;
  logic        busy_r;
  logic        dq_oe_r;
  logic        data_valid_r;
  logic        err_timeout_r;
  logic        err_checksum_r;

  logic        shift_en_s;
  logic        latch_mode_s;
  logic        tmo_s;
  logic        valid_s;
  logic        cks_err_s;
  logic        poll_hit_s;
  logic        tmo_hit_s;
  logic [15:0] start_us_s;

  dht_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick_s),
    .ms_tick (ms_tick_s)
  );

  // Two-stage synchroniser; idles high like the pulled-up line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], dq_i};
    end
  end

`ifdef DHT_GLITCH_FILT_EN
  logic       line_r;
  logic [1:0] stab_cnt_r;

  // Accept a new level only after 4 consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_r     <= 1'b1;
      stab_cnt_r <= 2'd0;
    end else if (sync_r[1] == line_r) begin
      stab_cnt_r <= 2'd0;
    end else if (stab_cnt_r == 2'd3) begin
      line_r     <= sync_r[1];
      stab_cnt_r <= 2'd0;
    end else begin
      stab_cnt_r <= stab_cnt_r + 2'd1;
    end
  end

  assign line_s = line_r;
`else
  assign line_s = sync_r[1];
`endif

  // Edge-detect stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_prev_r <= 1'b1;
    end else begin
      line_prev_r <= line_s;
    end
  end

  assign rise_s     = line_s & ~line_prev_r;
  assign fall_s     = ~line_s & line_prev_r;
  assign poll_hit_s = (POLL_PERIOD_MS > 0) && (poll_cnt_r == 16'(POLL_PERIOD_MS));
  assign tmo_hit_s  = (phase_cnt_r == 16'(PHASE_TIMEOUT_US));
  assign start_us_s = mode_r ? 16'(DHT22_START_US) : 16'(DHT11_START_US);

  // Next-state and single-cycle event decode.
  always_comb begin
    state_nxt_s  = state_r;
    shift_en_s   = 1'b0;
    latch_mode_s = 1'b0;
    tmo_s        = 1'b0;
    valid_s      = 1'b0;
    cks_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start || poll_hit_s) begin
          state_nxt_s  = ST_START;
          latch_mode_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (phase_cnt_r == start_us_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_RELEASE, ST_RESP_HIGH: begin
        if (fall_s) begin
          state_nxt_s = (state_r == ST_RELEASE) ? ST_RESP_LOW : ST_BIT_LOW;
        end else if (tmo_hit_s) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RESP_LOW, ST_BIT_LOW: begin
        if (rise_s) begin
          state_nxt_s = (state_r == ST_RESP_LOW) ? ST_RESP_HIGH : ST_BIT_HIGH;
        end else if (tmo_hit_s) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_BIT_HIGH: begin
        if (fall_s) begin
          shift_en_s  = 1'b1;
          state_nxt_s = (bit_cnt_r == 6'(FRAME_BITS - 1)) ? ST_CHECK : ST_BIT_LOW;
        end else if (tmo_hit_s) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BIT_HIGH;
        end
      end
      ST_CHECK: begin
        state_nxt_s = ST_IDLE;
        if (dht_frame_ok(shift_r)) begin
          valid_s = 1'b1;
        end else begin
          cks_err_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      phase_cnt_r    <= 16'd0;
      poll_cnt_r     <= 16'd0;
      width_cnt_r    <= 8'd0;
      bit_cnt_r      <= 6'd0;
      shift_r        <= 40'd0;
      raw_r          <= 40'd0;
      mode_r         <= 1'b0;
      busy_r         <= 1'b0;
      dq_oe_r        <= 1'b0;
      data_valid_r   <= 1'b0;
      err_timeout_r  <= 1'b0;
      err_checksum_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      busy_r         <= (state_nxt_s != ST_IDLE);
      dq_oe_r        <= (state_nxt_s == ST_START);
      data_valid_r   <= valid_s;
      err_timeout_r  <= tmo_s;
      err_checksum_r <= cks_err_s;

      if (state_nxt_s != state_r) begin
        phase_cnt_r <= 16'd0;
      end else if (tick_s && (phase_cnt_r != 16'hFFFF)) begin
        phase_cnt_r <= phase_cnt_r + 16'd1;
      end

      if ((state_r != ST_IDLE) || (state_nxt_s != ST_IDLE)) begin
        poll_cnt_r <= 16'd0;
      end else if ((POLL_PERIOD_MS > 0) && ms_tick_s) begin
        poll_cnt_r <= poll_cnt_r + 16'd1;
      end

      // High-pulse width in us, saturating so a stuck line cannot wrap to a short pulse.
      if ((state_r == ST_BIT_LOW) && rise_s) begin
        width_cnt_r <= 8'd0;
      end else if ((state_r == ST_BIT_HIGH) && tick_s && (width_cnt_r != 8'hFF)) begin
        width_cnt_r <= width_cnt_r + 8'd1;
      end

      if ((state_r == ST_RESP_HIGH) && fall_s) begin
        bit_cnt_r <= 6'd0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end

      if (shift_en_s) begin
        shift_r <= {shift_r[38:0], (width_cnt_r > 8'(BIT_THRESH_US))};
      end
      if (valid_s) begin
        raw_r <= shift_r;
      end
      if (latch_mode_s) begin
        mode_r <= bus.mode;
      end
    end
  end

  assign dq_oe            = dq_oe_r;
  assign bus.busy         = busy_r;
  assign bus.data_valid   = data_valid_r;
  assign bus.err_timeout  = err_timeout_r;
  assign bus.err_checksum = err_checksum_r;
  assign bus.raw          = raw_r;
  assign bus.humidity     = raw_r[39:24];
  assign bus.temperature  = raw_r[23:8];

endmodule
